// File: rtl/instrument_normalizer.sv
`timescale 1ns/1ps
// instrument_normalizer: turns signed 16.16 flight state into wrapped/clamped display integers.
// Heading wrap is resolved one correction per cycle; outputs only change on commit.
module instrument_normalizer #(
    parameter int unsigned HEADING_MOD  = 360,
    parameter int unsigned ALT_MAX      = 9999,
    parameter int unsigned SPEED_MAX    = 277,
    parameter int unsigned THROTTLE_MAX = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  raw_throttle,
    input  logic [31:0] raw_heading,
    input  logic [31:0] raw_altitude,
    input  logic [31:0] raw_speed,
    output logic [7:0]  throttle,
    output logic [15:0] heading,
    output logic [15:0] altitude,
    output logic [15:0] speed,
    output logic        out_valid
);
    localparam int unsigned HW = 17;
    localparam int unsigned IW = 16;
    localparam int unsigned TW = 8;

    localparam logic [HW-1:0] HMOD     = HW'(HEADING_MOD);
    localparam logic [IW-1:0] ALT_CEIL = IW'(ALT_MAX);
    localparam logic [IW-1:0] SPD_CEIL = IW'(SPEED_MAX);
    localparam logic [TW-1:0] THR_CEIL = TW'(THROTTLE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WRAP = 2'd1
    } state_t;

    state_t         r_state;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [HW-1:0]  r_h;
    logic [TW-1:0]  r_thr;
    logic [IW-1:0]  r_alt;
    logic [IW-1:0]  r_spd;
    logic [TW-1:0]  r_throttle;
    logic [IW-1:0]  r_heading;
    logic [IW-1:0]  r_altitude;
    logic [IW-1:0]  r_speed;

    logic           w_h_neg;
    logic           w_h_high;
    logic [HW-1:0]  w_h_fix;
    logic [IW-1:0]  w_alt_clamp;
    logic [IW-1:0]  w_spd_clamp;
    logic [TW-1:0]  w_thr_clamp;
    logic           w_unused;

    // Fractional bits are discarded by design.
    assign w_unused = ^{raw_heading[15:0], raw_altitude[15:0], raw_speed[15:0]};

    // One wrap step toward [0, HEADING_MOD).
    assign w_h_neg  = r_h[HW-1];
    assign w_h_high = !w_h_neg && (r_h >= HMOD);
    assign w_h_fix  = w_h_neg ? (r_h + HMOD) : (r_h - HMOD);

    // Negative integers (sign bit set) clamp to zero, otherwise unsigned ceiling compare.
    assign w_alt_clamp = r_alt[IW-1] ? '0 : ((r_alt > ALT_CEIL) ? ALT_CEIL : r_alt);
    assign w_spd_clamp = r_spd[IW-1] ? '0 : ((r_spd > SPD_CEIL) ? SPD_CEIL : r_spd);
    assign w_thr_clamp = (r_thr > THR_CEIL) ? THR_CEIL : r_thr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_h         <= '0;
            r_thr       <= '0;
            r_alt       <= '0;
            r_spd       <= '0;
            r_throttle  <= '0;
            r_heading   <= '0;
            r_altitude  <= '0;
            r_speed     <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_thr      <= raw_throttle;
                        r_alt      <= raw_altitude[31:16];
                        r_spd      <= raw_speed[31:16];
                        r_h        <= {raw_heading[31], raw_heading[31:16]};
                        r_in_ready <= 1'b0;
                        r_state    <= S_WRAP;
                    end
                end
                S_WRAP: begin
                    r_in_ready <= 1'b0;
                    if (w_h_neg || w_h_high) begin
                        r_h <= w_h_fix;
                    end else begin
                        r_throttle  <= w_thr_clamp;
                        r_heading   <= r_h[IW-1:0];
                        r_altitude  <= w_alt_clamp;
                        r_speed     <= w_spd_clamp;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign throttle  = r_throttle;
    assign heading   = r_heading;
    assign altitude  = r_altitude;
    assign speed     = r_speed;

endmodule

// File: tb/tb_instrument_normalizer.sv
`timescale 1ns/1ps
// Bench for instrument_normalizer: directed scenarios plus randomized samples against
// an arithmetic reference (modulo for heading, min/max for clamps, closed-form latency).
module tb_instrument_normalizer;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  raw_throttle;
    logic [31:0] raw_heading;
    logic [31:0] raw_altitude;
    logic [31:0] raw_speed;
    logic [7:0]  throttle;
    logic [15:0] heading;
    logic [15:0] altitude;
    logic [15:0] speed;
    logic        out_valid;

    int errors = 0;
    int checks = 0;

    logic [7:0]  e_thr = '0;
    logic [15:0] e_hd  = '0;
    logic [15:0] e_alt = '0;
    logic [15:0] e_spd = '0;

    instrument_normalizer dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .raw_throttle (raw_throttle),
        .raw_heading  (raw_heading),
        .raw_altitude (raw_altitude),
        .raw_speed    (raw_speed),
        .throttle     (throttle),
        .heading      (heading),
        .altitude     (altitude),
        .speed        (speed),
        .out_valid    (out_valid)
    );

    always #5 clk = ~clk;

    function automatic int f_int(input logic [31:0] r);
        logic signed [15:0] s;
        s = r[31:16];
        return int'(s);
    endfunction

    function automatic logic [15:0] m_heading(input logic [31:0] r);
        int m;
        m = f_int(r) % 360;
        if (m < 0) m += 360;
        return 16'(m);
    endfunction

    function automatic int m_corrections(input logic [31:0] r);
        int i;
        i = f_int(r);
        if (i < 0) return (-i + 359) / 360;
        return i / 360;
    endfunction

    function automatic logic [15:0] m_clamp(input logic [31:0] r, input int ceil_v);
        int i;
        i = f_int(r);
        if (i < 0) return 16'd0;
        if (i > ceil_v) return 16'(ceil_v);
        return 16'(i);
    endfunction

    function automatic logic [7:0] m_thr(input logic [7:0] t);
        return (t > 8'd100) ? 8'd100 : t;
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is first seen.
    task automatic do_sample(input logic [7:0] thr, input logic [31:0] hd,
                             input logic [31:0] alt, input logic [31:0] spd,
                             input bit noise, input bit check_drop);
        int  n_exp;
        int  lat;
        bit  seen;
        n_exp = m_corrections(hd);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: in_ready=%b want 1", in_ready);
        end
        raw_throttle = thr;
        raw_heading  = hd;
        raw_altitude = alt;
        raw_speed    = spd;
        in_valid     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int j = 0; j < 200 && !seen; j++) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                lat  = j;
            end else begin
                checks++;
                if ({throttle, heading, altitude, speed, in_ready} !== {e_thr, e_hd, e_alt, e_spd, 1'b0}) begin
                    errors++;
                    $display("FAIL hold: thr=%0d hd=%0d alt=%0d spd=%0d rdy=%b want %0d %0d %0d %0d 0",
                             throttle, heading, altitude, speed, in_ready, e_thr, e_hd, e_alt, e_spd);
                end
                if (noise) begin
                    in_valid     = 1'($urandom_range(0, 1));
                    raw_throttle = 8'($urandom);
                    raw_heading  = $urandom;
                    raw_altitude = $urandom;
                    raw_speed    = $urandom;
                end
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout: no out_valid for heading %h, want after %0d edges", hd, n_exp + 1);
        end else if (lat != n_exp + 1) begin
            errors++;
            $display("FAIL latency: heading %h committed after %0d edges, want %0d", hd, lat, n_exp + 1);
        end
        e_thr = m_thr(thr);
        e_hd  = m_heading(hd);
        e_alt = m_clamp(alt, 9999);
        e_spd = m_clamp(spd, 277);
        checks++;
        if ({throttle, heading, altitude, speed} !== {e_thr, e_hd, e_alt, e_spd}) begin
            errors++;
            $display("FAIL values: in %0d/%h/%h/%h got %0d %0d %0d %0d want %0d %0d %0d %0d",
                     thr, hd, alt, spd, throttle, heading, altitude, speed, e_thr, e_hd, e_alt, e_spd);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL commit_ready: in_ready=%b want 1", in_ready);
        end
        if (check_drop) begin
            @(negedge clk);
            checks++;
            if ({out_valid, throttle, heading, altitude, speed} !== {1'b0, e_thr, e_hd, e_alt, e_spd}) begin
                errors++;
                $display("FAIL pulse_drop: ov=%b hd=%0d want ov=0 hd=%0d", out_valid, heading, e_hd);
            end
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        in_valid     = 1'b1;
        raw_throttle = 8'd50;
        raw_heading  = 32'h0005_0000;
        raw_altitude = 32'h0064_0000;
        raw_speed    = 32'h000A_0000;
        repeat (3) @(negedge clk);
        checks++;
        if ({throttle, heading, altitude, speed} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: %0d %0d %0d %0d want 0", throttle, heading, altitude, speed);
        end
        checks++;
        if ({in_ready, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: rdy=%b ov=%b want 0 0", in_ready, out_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL release_ready: rdy=%b ov=%b want 1 0", in_ready, out_valid);
        end
        do_sample(8'd50, 32'h0005_0000, 32'h0064_0000, 32'h000A_0000, 1'b0, 1'b1);
    endtask

    task automatic test_wrap_positive();
        do_sample(8'd0, 32'h0172_8000, 32'h0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (heading !== 16'd10) begin
            errors++;
            $display("FAIL wrap_370: heading=%0d want 10", heading);
        end
    endtask

    task automatic test_back_to_back();
        do_sample(8'd0, 32'hFFFE_C000, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (heading !== 16'd358) begin
            errors++;
            $display("FAIL wrap_neg: heading=%0d want 358", heading);
        end
        do_sample(8'd0, 32'h0000_0000, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_boundaries();
        do_sample(8'd7, 32'h0168_0000, 32'h0, 32'h0, 1'b0, 1'b1);
        do_sample(8'd7, 32'h0167_FFFF, 32'h0, 32'h0, 1'b0, 1'b1);
        do_sample(8'd7, 32'hFE98_0000, 32'h0, 32'h0, 1'b0, 1'b1);
        do_sample(8'd7, 32'h7FFF_0000, 32'h0, 32'h0, 1'b0, 1'b1);
        do_sample(8'd7, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (heading !== 16'd352) begin
            errors++;
            $display("FAIL wrap_min: heading=%0d want 352", heading);
        end
    endtask

    task automatic test_clamps();
        do_sample(8'd150, 32'h0, 32'hFFFB_0000, 32'h012C_0000, 1'b0, 1'b1);
        do_sample(8'd100, 32'h0, 32'h2EE0_0000, 32'hFFFD_0000, 1'b0, 1'b1);
        do_sample(8'd99,  32'h0, 32'h270F_8000, 32'h0115_4000, 1'b0, 1'b1);
        do_sample(8'd255, 32'h0, 32'h2710_0000, 32'h0116_0000, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_wrap();
        do_sample(8'd33, 32'h0010_0000, 32'h0020_0000, 32'h0030_0000, 1'b0, 1'b1);
        raw_heading = 32'h8000_0000;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (39) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({throttle, heading, altitude, speed, out_valid, in_ready} !== '0) begin
            errors++;
            $display("FAIL midwrap_reset: %0d %0d %0d %0d ov=%b rdy=%b want all 0",
                     throttle, heading, altitude, speed, out_valid, in_ready);
        end
        e_thr = '0; e_hd = '0; e_alt = '0; e_spd = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midwrap_pulse: out_valid=%b want 0", out_valid);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        do_sample(8'd20, 32'h02D0_0000, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] hd;
        logic [31:0] alt;
        logic [31:0] spd;
        for (int k = 0; k < 20; k++) begin
            hd  = $urandom;
            alt = (k % 2 == 0) ? {16'($urandom_range(0, 12000)), 16'($urandom)} : $urandom;
            spd = (k % 3 == 0) ? {16'($urandom_range(0, 400)), 16'($urandom)} : $urandom;
            do_sample(8'($urandom), hd, alt, spd, 1'(k % 2), 1'(k % 4 != 3));
        end
    endtask

    initial begin
        test_reset();
        test_wrap_positive();
        test_back_to_back();
        test_boundaries();
        test_clamps();
        test_reset_mid_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
